simd_acc: RTL

- Downstream consumer of the SIMD adder stage.
- Takes each registered SIMD result (Y_r/valid_r plus the op that produced it, delayed one cycle to align) and accumulates it per lane over a programmable batch of results.
- Lane width (32/16/8) comes from the op. Each lane wraps or signed-saturates.
- Completed sums go into a small output queue with a valid/ready handshake.
- Drives a credit-style in_rdy, which upstream issue control uses to gate `pass`.

---
 rtl/simd_pkg.sv | 31 +++
 rtl/simd_acc_if.sv | 25 ++
 rtl/simd_acc_fifo.sv | 56 +++++
 rtl/simd_acc.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared SIMD datapath types: op codes, data word, lane modes and the
// accumulator result record consumed by the output queue.
package simd_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [3:0] {
      ADD32, SUB32, SEL0, SEL1,
      ADD16, SUB16, ADDSUB16, SUBADD16,
      ADD8, SUB8, ADDSUB8, SUBADD8
   } op_t;

   typedef enum logic [1:0] {LM_32, LM_16, LM_8} lane_mode_t;

   typedef enum logic {ST_IDLE, ST_ACC} acc_state_t;

   typedef struct packed {
      word_t      sum;
      logic [3:0] ovf;
      logic       err;
   } acc_result_t;

   function automatic lane_mode_t op_to_lane_mode(input op_t op);
      case (op)
         ADD32, SUB32, SEL0, SEL1:           return LM_32;
         ADD16, SUB16, ADDSUB16, SUBADD16:   return LM_16;
         default:                            return LM_8;
      endcase
   endfunction

endpackage

// File: rtl/simd_acc_if.sv
// Result stream into the accumulator and completed-sum stream out of it.
interface simd_acc_if;
   import simd_pkg::*;

   logic       in_vld;
   op_t        in_op;
   word_t      in_y;
   logic       in_rdy;
   logic       out_vld;
   logic       out_rdy;
   word_t      out_sum;
   logic [3:0] out_ovf;
   logic       out_err;

   modport slave (
      input  in_vld, in_op, in_y, out_rdy,
      output in_rdy, out_vld, out_sum, out_ovf, out_err
   );

   modport master (
      output in_vld, in_op, in_y, out_rdy,
      input  in_rdy, out_vld, out_sum, out_ovf, out_err
   );

endinterface

// File: rtl/simd_acc_fifo.sv
// Small in-order queue of accumulator results; a push into a full queue is
// accepted only if a pop frees a slot in the same cycle, otherwise dropped.
module simd_acc_fifo
   import simd_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  acc_result_t      din,
   input  logic             pop,
   output acc_result_t      dout,
   output logic [CNT_W-1:0] count,
   output logic             drop
);

   localparam int PTR_W = $clog2(DEPTH);

   acc_result_t      mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic             full, empty, wr, rd;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign rd    = pop & ~empty;
   assign wr    = push & (~full | rd);
   assign drop  = push & full & ~rd;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= ptr_inc(wr_ptr);
         if (rd) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr, rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/simd_acc.sv
// Per-lane batch accumulator behind the SIMD adder: sums a programmable number
// of results lane-wise (wrap or signed saturate) and queues the batch totals.
module simd_acc
   import simd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   simd_acc_if.slave        bus,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_sat,
   input  logic             clr,
   output logic             drop_r
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [LEN_W:0] LEN_ONE = (LEN_W + 1)'(1);

   acc_state_t       state, state_nx;
   word_t            acc_p0, acc_nx;
   logic [LEN_W:0]   cnt_p0, cnt_nx, cnt_inc, len_p0, len_nx, cfg_len_ext;
   lane_mode_t       mode_p0, mode_nx;
   logic             sat_p0, sat_nx;
   logic [3:0]       ovf_p0, ovf_nx;
   logic             err_p0, err_nx;
   logic             vld_p1, vld_nx;
   acc_result_t      res_p1, res_nx;
   logic [35:0]      add_res;
   acc_result_t      fifo_dout;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_drop, pop;

   function automatic logic [8:0] add8(input logic signed [7:0] a, input logic signed [7:0] b,
                                       input logic sat);
      logic signed [7:0] s;
      logic              o;
      s = a + b;
      o = (a[7] == b[7]) && (s[7] != a[7]);
      if (o && sat) s = a[7] ? 8'sh80 : 8'sh7f;
      return {o, s};
   endfunction

   function automatic logic [16:0] add16(input logic signed [15:0] a, input logic signed [15:0] b,
                                         input logic sat);
      logic signed [15:0] s;
      logic               o;
      s = a + b;
      o = (a[15] == b[15]) && (s[15] != a[15]);
      if (o && sat) s = a[15] ? 16'sh8000 : 16'sh7fff;
      return {o, s};
   endfunction

   function automatic logic [32:0] add32(input logic signed [31:0] a, input logic signed [31:0] b,
                                         input logic sat);
      logic signed [31:0] s;
      logic               o;
      s = a + b;
      o = (a[31] == b[31]) && (s[31] != a[31]);
      if (o && sat) s = a[31] ? 32'sh8000_0000 : 32'sh7fff_ffff;
      return {o, s};
   endfunction

   // Result layout {ovf[3:0], sum[31:0]}; ovf lands on each lane's top byte.
   function automatic logic [35:0] lane_add(input word_t a, input word_t b,
                                            input lane_mode_t m, input logic sat);
      logic [35:0] r;
      logic [32:0] r32;
      logic [16:0] r16;
      logic [8:0]  r8;
      r = '0;
      case (m)
         LM_32: begin
            r32      = add32(a, b, sat);
            r[31:0]  = r32[31:0];
            r[35]    = r32[32];
         end
         LM_16: begin
            for (int i = 0; i < 2; i++) begin
               r16            = add16(a[16*i +: 16], b[16*i +: 16], sat);
               r[16*i +: 16]  = r16[15:0];
               r[33 + 2*i]    = r16[16];
            end
         end
         LM_8: begin
            for (int i = 0; i < 4; i++) begin
               r8           = add8(a[8*i +: 8], b[8*i +: 8], sat);
               r[8*i +: 8]  = r8[7:0];
               r[32 + i]    = r8[8];
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   assign cfg_len_ext = (cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cfg_len};
   assign cnt_inc     = cnt_p0 + 1'b1;
   assign add_res     = lane_add(acc_p0, bus.in_y, mode_p0, sat_p0);

   always_comb begin
      state_nx = state;
      acc_nx   = acc_p0;
      cnt_nx   = cnt_p0;
      len_nx   = len_p0;
      mode_nx  = mode_p0;
      sat_nx   = sat_p0;
      ovf_nx   = ovf_p0;
      err_nx   = err_p0;
      vld_nx   = 1'b0;
      res_nx   = res_p1;
      if (clr) begin
         state_nx = ST_IDLE;
         acc_nx   = '0;
         cnt_nx   = '0;
         ovf_nx   = '0;
         err_nx   = 1'b0;
      end else if (bus.in_vld) begin
         case (state)
            ST_IDLE: begin
               mode_nx = op_to_lane_mode(bus.in_op);
               len_nx  = cfg_len_ext;
               sat_nx  = cfg_sat;
               ovf_nx  = '0;
               err_nx  = 1'b0;
               if (cfg_len_ext == LEN_ONE) begin
                  vld_nx     = 1'b1;
                  res_nx.sum = bus.in_y;
                  res_nx.ovf = '0;
                  res_nx.err = 1'b0;
                  acc_nx     = '0;
                  cnt_nx     = '0;
               end else begin
                  acc_nx   = bus.in_y;
                  cnt_nx   = LEN_ONE;
                  state_nx = ST_ACC;
               end
            end
            ST_ACC: begin
               if (cnt_inc == len_p0) begin
                  vld_nx     = 1'b1;
                  res_nx.sum = add_res[31:0];
                  res_nx.ovf = ovf_p0 | add_res[35:32];
                  res_nx.err = err_p0 | (op_to_lane_mode(bus.in_op) != mode_p0);
                  acc_nx     = '0;
                  cnt_nx     = '0;
                  ovf_nx     = '0;
                  err_nx     = 1'b0;
                  state_nx   = ST_IDLE;
               end else begin
                  acc_nx = add_res[31:0];
                  cnt_nx = cnt_inc;
                  ovf_nx = ovf_p0 | add_res[35:32];
                  err_nx = err_p0 | (op_to_lane_mode(bus.in_op) != mode_p0);
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // p0: accumulator stage
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         acc_p0 <= '0;
         cnt_p0 <= '0;
         ovf_p0 <= '0;
         err_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         drop_r <= 1'b0;
      end else begin
         state  <= state_nx;
         acc_p0 <= acc_nx;
         cnt_p0 <= cnt_nx;
         ovf_p0 <= ovf_nx;
         err_p0 <= err_nx;
         vld_p1 <= vld_nx;
         if (fifo_drop) drop_r <= 1'b1;
      end
   end

   // p1: push register feeding the queue
   always_ff @(posedge clk) begin
      len_p0  <= len_nx;
      mode_p0 <= mode_nx;
      sat_p0  <= sat_nx;
      res_p1  <= res_nx;
   end

   assign pop = bus.out_vld & bus.out_rdy;

   simd_acc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (vld_p1),
      .din   (res_p1),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .drop  (fifo_drop)
   );

   // Three free slots cover the beat in the SIMD stage, the accumulator and the push register.
   assign bus.in_rdy  = (CNT_W'(DEPTH) - fifo_count) >= CNT_W'(3);
   assign bus.out_vld = (fifo_count != '0);
   assign bus.out_sum = fifo_dout.sum;
   assign bus.out_ovf = fifo_dout.ovf;
   assign bus.out_err = fifo_dout.err;

endmodule
